// File: rtl/aes_usb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_usb_pkg
//  Description : Shared block geometry and assembler FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_usb_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_BITS  = 128;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/idle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : idle_timer
//  Description : Saturating idle counter with synchronous clear and a
//                terminal-count flag raised when the count equals MAX_COUNT.
//  Revision    : 1.0  initial release
// ============================================================================
module idle_timer #(
    parameter int MAX_COUNT = 4095
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int c_CNT_W = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);

    logic [c_CNT_W-1:0] r_count;
    logic               w_at_max;

    assign w_at_max   = (r_count == c_CNT_W'(MAX_COUNT));
    assign o_terminal = w_at_max;

    // Count idle cycles; clear wins, and the count sticks at its ceiling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_at_max) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/plain_block_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : plain_block_assembler
//  Description : Packs bytes from a show-ahead FIFO into 128-bit AES blocks,
//                first byte in the top lane, and holds each block until the
//                core acknowledges it.
//                Build macro PLAIN_PAD_EN enables PKCS#7 padding of partial
//                blocks on flush or after IDLE_TIMEOUT idle cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module plain_block_assembler
    import aes_usb_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 4095
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_empty,
    input  logic [7:0]            rx_data,
    output logic                  rx_r_enable,
    input  logic                  flush,
    output logic [BLOCK_BITS-1:0] block_data,
    output logic                  block_valid,
    input  logic                  block_ack,
    output logic [4:0]            byte_count,
    output logic                  padded
);

    state_t                r_state;
    state_t                w_next_state;
    logic [BLOCK_BITS-1:0] r_block_data;
    logic [BLOCK_BITS-1:0] w_next_data;
    logic [4:0]            r_byte_count;
    logic [4:0]            w_next_count;
    logic                  r_run;
    logic                  w_pad_trigger;
    logic                  w_pop;
    logic                  w_wr_en;
    logic [7:0]            w_wr_byte;

`ifdef PLAIN_PAD_EN
    logic       r_padded;
    logic       w_next_padded;
    logic [7:0] r_pad_value;
    logic [7:0] w_next_pad_value;
    logic       w_timeout;

    idle_timer #(
        .MAX_COUNT (IDLE_TIMEOUT)
    ) u_idle_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_pop || (r_byte_count == 5'd0)),
        .i_enable   (r_state == FILL),
        .o_terminal (w_timeout)
    );

    // Only a partially filled block can be closed early.
    assign w_pad_trigger = (r_state == FILL) && (r_byte_count != 5'd0) &&
                           (flush || w_timeout);
    assign padded        = r_padded;
`else
    logic w_unused_cfg;

    assign w_unused_cfg  = flush ^ (IDLE_TIMEOUT != 0);
    assign w_pad_trigger = 1'b0;
    assign padded        = 1'b0;
`endif

    // Pops are held off until the first edge after reset is released,
    // so no pop can ever be issued while rst is asserted.
    assign w_pop       = r_run && (r_state == FILL) && !rx_empty && !w_pad_trigger;
    assign rx_r_enable = w_pop;
    assign block_valid = (r_state == HOLD);
    assign block_data  = r_block_data;
    assign byte_count  = r_byte_count;

    // Enable pops once reset has been released for one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Next-state, byte placement and block release decisions.
    always_comb begin
        w_next_state = r_state;
        w_next_data  = r_block_data;
        w_next_count = r_byte_count;
        w_wr_en      = 1'b0;
        w_wr_byte    = rx_data;
`ifdef PLAIN_PAD_EN
        w_next_padded    = r_padded;
        w_next_pad_value = r_pad_value;
`endif
        case (r_state)
            FILL: begin
                if (w_pad_trigger) begin
                    w_next_state = PAD;
`ifdef PLAIN_PAD_EN
                    w_next_pad_value = 8'(BLOCK_BYTES) - {3'b000, r_byte_count};
`endif
                end else if (w_pop) begin
                    w_wr_en      = 1'b1;
                    w_next_count = r_byte_count + 5'd1;
                    if (r_byte_count == 5'(BLOCK_BYTES - 1)) begin
                        w_next_state = HOLD;
                    end
                end
            end
`ifdef PLAIN_PAD_EN
            PAD: begin
                w_wr_en      = 1'b1;
                w_wr_byte    = r_pad_value;
                w_next_count = r_byte_count + 5'd1;
                if (r_byte_count == 5'(BLOCK_BYTES - 1)) begin
                    w_next_state  = HOLD;
                    w_next_padded = 1'b1;
                end
            end
`endif
            HOLD: begin
                if (block_ack) begin
                    w_next_state = FILL;
                    w_next_data  = '0;
                    w_next_count = 5'd0;
`ifdef PLAIN_PAD_EN
                    w_next_padded = 1'b0;
`endif
                end
            end
            default: begin
                w_next_state = FILL;
            end
        endcase

        if (w_wr_en) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                if (r_byte_count == 5'(i)) begin
                    w_next_data[BLOCK_BITS-1-8*i -: 8] = w_wr_byte;
                end
            end
        end
    end

    // State and block registers; reset discards any partial block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FILL;
            r_block_data <= '0;
            r_byte_count <= 5'd0;
`ifdef PLAIN_PAD_EN
            r_padded     <= 1'b0;
            r_pad_value  <= 8'd0;
`endif
        end else begin
            r_state      <= w_next_state;
            r_block_data <= w_next_data;
            r_byte_count <= w_next_count;
`ifdef PLAIN_PAD_EN
            r_padded     <= w_next_padded;
            r_pad_value  <= w_next_pad_value;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_plain_block_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plain_block_assembler
//  Description : Self-checking bench for plain_block_assembler with a queue
//                based FIFO model and block-level expected values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_plain_block_assembler;

    localparam int c_IDLE_TO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_empty;
    logic [7:0]   rx_data;
    logic         rx_r_enable;
    logic         flush;
    logic [127:0] block_data;
    logic         block_valid;
    logic         block_ack;
    logic [4:0]   byte_count;
    logic         padded;

    logic [7:0] fifo[$];
    int cyc = 0;
    int pops = 0;
    int last_pop_edge = 0;
    int passes = 0;
    int fails = 0;
    int total = 0;

    always #5 clk = ~clk;

    plain_block_assembler #(
        .IDLE_TIMEOUT (c_IDLE_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_empty    (rx_empty),
        .rx_data     (rx_data),
        .rx_r_enable (rx_r_enable),
        .flush       (flush),
        .block_data  (block_data),
        .block_valid (block_valid),
        .block_ack   (block_ack),
        .byte_count  (byte_count),
        .padded      (padded)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        rx_empty = (fifo.size() == 0);
        rx_data  = rx_empty ? 8'h00 : fifo[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        drive_fifo();
    endtask

    // One clock: sample the pop strobe, consume from the FIFO model on the
    // edge, then refresh the FIFO head after the falling edge.
    task automatic tick();
        logic pop_now;
        #1;
        pop_now = rx_r_enable;
        @(posedge clk);
        cyc++;
        if (pop_now && fifo.size() != 0) begin
            void'(fifo.pop_front());
            pops++;
            last_pop_edge = cyc;
        end
        @(negedge clk);
        drive_fifo();
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!block_valid && n < budget) begin
            tick();
            n++;
        end
        chk("valid_reached", block_valid, 1'b1);
    endtask

    task automatic wait_count(input int cnt, input int budget);
        int n = 0;
        while (int'(byte_count) != cnt && n < budget) begin
            tick();
            n++;
        end
        chk("count_reached", byte_count, cnt);
    endtask

    task automatic ack();
        block_ack = 1'b1;
        tick();
        block_ack = 1'b0;
    endtask

    // Expected block: bytes in arrival order, first byte most significant.
    function automatic logic [127:0] pack(input logic [7:0] q[$]);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) r = {r[119:0], q[i]};
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   q[$];
        logic [7:0]   q2[$];
        logic [127:0] held;
        int           p0;
        int           e0;
        int           hold_pops;
        int           hold_changes;
        int           hold_invalid;

        rst = 1'b1; flush = 1'b0; block_ack = 1'b0;
        drive_fifo();
        repeat (3) tick();
        chk("rst_valid", block_valid, 1'b0);
        chk("rst_count", byte_count, 5'd0);
        chk("rst_data", block_data, 128'h0);
        chk("rst_padded", padded, 1'b0);
        chk("rst_pop", rx_r_enable, 1'b0);
        rst = 1'b0;
        tick();

        // Counting pattern 0x00..0x0F.
        p0 = pops;
        for (int i = 0; i < 16; i++) push(8'(i));
        wait_valid(40);
        chk("t1_latency", cyc - last_pop_edge + 1, 1);
        chk("t1_data", block_data, 128'h000102030405060708090A0B0C0D0E0F);
        chk("t1_padded", padded, 1'b0);
        chk("t1_count", byte_count, 5'd16);
        chk("t1_pops", pops - p0, 16);
        p0 = pops;
        ack();
        chk("t1_ack_nopop", pops - p0, 0);
        chk("t1_ack_valid", block_valid, 1'b0);
        chk("t1_ack_count", byte_count, 5'd0);
        chk("t1_ack_data", block_data, 128'h0);

        // Two blocks queued, ack delayed for ten cycles.
        q2 = {};
        for (int i = 0; i < 32; i++) q2.push_back(8'($urandom_range(0, 255)));
        p0 = pops;
        foreach (q2[i]) push(q2[i]);
        wait_valid(40);
        chk("t2_blk1_pops", pops - p0, 16);
        chk("t2_blk1_data", block_data, pack(q2));
        held = block_data;
        hold_pops = pops;
        hold_changes = 0;
        hold_invalid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (block_data !== held) hold_changes++;
            if (block_valid !== 1'b1) hold_invalid++;
        end
        chk("t2_hold_pops", pops - hold_pops, 0);
        chk("t2_hold_stable", hold_changes, 0);
        chk("t2_hold_valid", hold_invalid, 0);
        ack();
        chk("t2_ack_nopop", pops - hold_pops, 0);
        q = q2[16:$];
        wait_valid(40);
        chk("t2_blk2_data", block_data, pack(q));
        chk("t2_total_pops", pops - p0, 32);
        ack();

        // Reset in the middle of a block, with bytes waiting during reset.
        for (int i = 0; i < 7; i++) push(8'($urandom_range(0, 255)));
        wait_count(7, 20);
        rst = 1'b1;
        #1;
        chk("rst_mid_count", byte_count, 5'd0);
        chk("rst_mid_data", block_data, 128'h0);
        chk("rst_mid_pop", rx_r_enable, 1'b0);
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(8'($urandom_range(0, 255)));
        foreach (q[i]) push(q[i]);
        p0 = pops;
        repeat (3) tick();
        chk("rst_nopop", pops - p0, 0);
        rst = 1'b0;
        wait_valid(40);
        chk("rst_clean_data", block_data, pack(q));
        chk("rst_clean_padded", padded, 1'b0);
        ack();

        // Flush with an empty block does nothing.
        flush = 1'b1;
        repeat (12) tick();
        chk("flush0_valid", block_valid, 1'b0);
        chk("flush0_count", byte_count, 5'd0);
        flush = 1'b0;

`ifdef PLAIN_PAD_EN
        // Five 0xAA bytes closed by flush; flush stays high through PAD/HOLD.
        q = {};
        for (int i = 0; i < 5; i++) begin
            q.push_back(8'hAA);
            push(8'hAA);
        end
        wait_count(5, 20);
        flush = 1'b1;
        e0 = cyc;
        wait_valid(30);
        chk("flush_latency", cyc - e0, 12);
        while (q.size() < 16) q.push_back(8'(16 - 5));
        chk("flush_data", block_data, pack(q));
        chk("flush_padded", padded, 1'b1);
        flush = 1'b0;
        ack();
        chk("flush_ack_padded", padded, 1'b0);

        // Three bytes then silence: idle timeout closes the block.
        q = {};
        for (int i = 0; i < 3; i++) q.push_back(8'($urandom_range(0, 255)));
        foreach (q[i]) push(q[i]);
        wait_count(3, 20);
        e0 = last_pop_edge;
        wait_valid(60);
        chk("idle_latency", cyc - e0, 1 + c_IDLE_TO + 13);
        while (q.size() < 16) q.push_back(8'h0D);
        chk("idle_data", block_data, pack(q));
        chk("idle_padded", padded, 1'b1);
        ack();
`else
        // Without padding, flush cannot close a partial block.
        q = {};
        for (int i = 0; i < 5; i++) q.push_back(8'($urandom_range(0, 255)));
        foreach (q[i]) push(q[i]);
        wait_count(5, 20);
        flush = 1'b1;
        e0 = cyc;
        repeat (20) tick();
        chk("noflush_count", byte_count, 5'd5);
        chk("noflush_valid", block_valid, 1'b0);
        chk("noflush_padded", padded, 1'b0);
        chk("noflush_cycles", cyc - e0, 20);
        flush = 1'b0;
        for (int i = 0; i < 11; i++) q.push_back(8'($urandom_range(0, 255)));
        for (int i = 5; i < 16; i++) push(q[i]);
        wait_valid(30);
        chk("noflush_data", block_data, pack(q));
        ack();
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/plain_block_assembler.md
PLAIN_BLOCK_ASSEMBLER -- requirements
Module: plain_block_assembler

Interface
REQ-001 SHALL have parameter IDLE_TIMEOUT, default 4095, cycles without a pop before a partial block is padded (PLAIN_PAD_EN builds only).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx_empty  input  1  upstream byte FIFO empty.
REQ-005 SHALL have port rx_data  input  8  upstream FIFO head byte, show-ahead, valid when rx_empty=0.
REQ-006 SHALL have port rx_r_enable  output  1  pop strobe to upstream FIFO.
REQ-007 SHALL have port flush  input  1  request to close a partial block.
REQ-008 SHALL have port block_data  output  128  assembled plaintext block to the AES core.
REQ-009 SHALL have port block_valid  output  1  block_data complete and stable.
REQ-010 SHALL have port block_ack  input  1  AES core accepted block_data.
REQ-011 SHALL have port byte_count  output  5  bytes held, 0..16.
REQ-012 SHALL have port padded  output  1  current valid block contains padding.

Function
REQ-013 SHALL implement FSM states FILL, PAD, HOLD.
REQ-014 FILL: rx_r_enable=1 exactly when rx_empty=0 and no pad trigger, one byte per cycle, rx_data captured same edge.
REQ-015 First captured byte SHALL land in block_data[127:120], byte k in [127-8k:120-8k], MSB-first.
REQ-016 byte_count SHALL increment by one per capture; capture of 16th byte SHALL move FILL->HOLD on that edge.
REQ-017 HOLD: block_valid=1, rx_r_enable=0, block_data frozen until block_ack=1.
REQ-018 block_ack in HOLD SHALL on that edge clear block_data, byte_count, padded and return to FILL; no pop that cycle.
REQ-019 block_ack outside HOLD SHALL be ignored.
REQ-020 block_valid SHALL be 0 in FILL and PAD; latency last byte pop -> block_valid = 1 cycle.
REQ-021 Pad trigger (PLAIN_PAD_EN only): in FILL with byte_count in 1..15 and (flush=1 or idle counter = IDLE_TIMEOUT) -> PAD; trigger takes priority over a pop that cycle.
REQ-022 flush or timeout with byte_count=0 SHALL be ignored.
REQ-023 Idle counter SHALL clear on every pop and whenever byte_count=0, else increment in FILL, saturating at IDLE_TIMEOUT.
REQ-024 PAD: write one byte per cycle of value (16 - byte_count at PAD entry), PKCS#7, until byte_count=16, then HOLD with padded=1.
REQ-025 flush during PAD or HOLD SHALL be ignored.

Reset
REQ-026 rst SHALL asynchronously force FILL, block_data=0, byte_count=0, block_valid=0, padded=0, rx_r_enable=0, idle counter=0.
REQ-027 rst mid-block SHALL discard partial data; no pop SHALL occur while rst=1.

Configuration
REQ-028 Macro PLAIN_PAD_EN defined: PAD state, idle counter, flush and IDLE_TIMEOUT active.
REQ-029 PLAIN_PAD_EN undefined: no PAD state, no idle counter, flush ignored, padded tied 0; only full 16-byte blocks emitted.

Structure
REQ-030 Shared package aes_usb_pkg SHALL hold the FSM state enum, BLOCK_BYTES=16 and BLOCK_BITS=128 constants.
REQ-031 Idle counter SHALL be sub-module idle_timer (clear, enable, terminal-count output, width from IDLE_TIMEOUT).

Verification
REQ-032 Push 0x00..0x0F, ack when valid -> block_data=0x000102030405060708090A0B0C0D0E0F, valid 1 cycle after 16th pop, padded=0.
REQ-033 32 bytes queued, ack held 0 for 10 cycles -> exactly 16 pops, rx_r_enable=0 during HOLD, 2nd block pops start after ack.
REQ-034 PAD_EN: 5 bytes 0xAA then flush -> bytes 5..15 = 0x0B, padded=1, valid after 11 PAD cycles.
REQ-035 PAD_EN, IDLE_TIMEOUT=8: 3 bytes, FIFO empty -> PAD entered after 8 idle cycles, pad bytes 0x0D.
REQ-036 rst asserted after 7 bytes -> byte_count=0, block_data=0 immediately; next 16 bytes form a clean block.
REQ-037 flush with byte_count=0, and flush without PAD_EN -> no state change, block_valid stays 0.
